orb_m16_rx: RTL and testbench

ORB_M16_RX -- requirements
Module: orb_m16_rx

---
 rtl/orb_m16_rx.sv | 185 ++++++++++++++++++
 tb/tb_orb_m16_rx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/orb_m16_rx.sv
// M16 serial telemetry receiver: 4x oversampled bit recovery, phrase-marker
// frame sync (HUNT/CHECK/LOCK) and 12-bit word output while locked.
module orb_m16_rx #(
   parameter int CONFIRM  = 2,
   parameter int MISS_MAX = 3
) (
   input  logic        iClkOrb,
   input  logic        reset,
   input  logic        iOrbit,
   output logic [11:0] oParallel,
   output logic        oVal,
   output logic [4:0]  oPos,
   output logic        oLock,
   output logic        oSyncErr
);

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      CHECK = 2'd1,
      LOCK  = 2'd2
   } state_t;

   // Word MSB marker pattern per phrase position; position 16 is a free flag.
   localparam logic [31:0] MARK      = 32'h4504_0154;
   localparam logic [31:0] CARE      = 32'hFFFE_FFFF;
   localparam logic [7:0]  CONFIRM_C = 8'(CONFIRM);
   localparam logic [7:0]  MISS_C    = 8'(MISS_MAX);

   function automatic logic phraseMatch(input logic [383:0] hist);
      logic ok;
      ok = 1'b1;
      for (int p = 0; p < 32; p++) begin
         ok = ok & (~CARE[p] | (hist[12*(31-p)+11] ~^ MARK[p]));
      end
      return ok;
   endfunction

   logic          sync1R, sync2R, sPrevR;
   logic [1:0]    phaseR;
   logic [382:0]  histR;
   state_t        stateR, stateNext;
   logic [3:0]    bitCntR, bitCntNext;
   logic [4:0]    posR, posNext;
   logic [7:0]    confirmR, confirmNext;
   logic [7:0]    missR, missNext;
   logic          syncErrNext;

   logic          transS, sampleS, matchS, wordDoneS, phraseDoneS, wordOutS;
   logic [383:0]  histNextS;

   // The full 384-bit history only exists combinationally: its oldest bit is
   // needed for the match on the sample cycle and is then discarded.
   assign transS      = sync2R ^ sPrevR;
   assign sampleS     = (phaseR == 2'd2) && !transS;
   assign histNextS   = {histR, sync2R};
   assign matchS      = phraseMatch(histNextS);
   assign wordDoneS   = sampleS && (stateR != HUNT) && (bitCntR == 4'd11);
   assign phraseDoneS = wordDoneS && (posR == 5'd31);
   assign wordOutS    = wordDoneS && (stateNext == LOCK);

   // Input synchronizer and bit-phase recovery
   always_ff @(posedge iClkOrb or posedge reset) begin
      if (reset) begin
         sync1R <= 1'b0;
         sync2R <= 1'b0;
         sPrevR <= 1'b0;
         phaseR <= 2'd0;
      end else begin
         sync1R <= iOrbit;
         sync2R <= sync1R;
         sPrevR <= sync2R;
         if (transS) begin
            phaseR <= 2'd1;
         end else begin
            phaseR <= phaseR + 2'd1;
         end
      end
   end

   // Sampled-bit history, newest bit at index 0
   always_ff @(posedge iClkOrb or posedge reset) begin
      if (reset) begin
         histR <= {383{1'b0}};
      end else if (sampleS) begin
         histR <= histNextS[382:0];
      end
   end

   // Frame sync next-state and counter logic
   always_comb begin
      stateNext   = stateR;
      bitCntNext  = bitCntR;
      posNext     = posR;
      confirmNext = confirmR;
      missNext    = missR;
      syncErrNext = 1'b0;
      if (sampleS) begin
         case (stateR)
            HUNT: begin
               if (matchS) begin
                  stateNext   = CHECK;
                  bitCntNext  = 4'd0;
                  posNext     = 5'd0;
                  confirmNext = 8'd0;
               end else begin
                  stateNext = HUNT;
               end
            end
            CHECK, LOCK: begin
               if (bitCntR == 4'd11) begin
                  bitCntNext = 4'd0;
                  posNext    = posR + 5'd1;
               end else begin
                  bitCntNext = bitCntR + 4'd1;
               end
               if (!phraseDoneS) begin
                  stateNext = stateR;
               end else if (stateR == CHECK) begin
                  if (!matchS) begin
                     stateNext = HUNT;
                  end else if (confirmR + 8'd1 == CONFIRM_C) begin
                     stateNext   = LOCK;
                     confirmNext = confirmR + 8'd1;
                     missNext    = 8'd0;
                  end else begin
                     confirmNext = confirmR + 8'd1;
                  end
               end else if (matchS) begin
                  missNext = 8'd0;
               end else begin
                  syncErrNext = 1'b1;
                  missNext    = missR + 8'd1;
                  if (missR + 8'd1 == MISS_C) begin
                     stateNext = HUNT;
                  end else begin
                     stateNext = LOCK;
                  end
               end
            end
            default: begin
               stateNext = HUNT;
            end
         endcase
      end else begin
         stateNext = stateR;
      end
   end

   // Frame sync state and counters
   always_ff @(posedge iClkOrb or posedge reset) begin
      if (reset) begin
         stateR   <= HUNT;
         bitCntR  <= 4'd0;
         posR     <= 5'd0;
         confirmR <= 8'd0;
         missR    <= 8'd0;
      end else begin
         stateR   <= stateNext;
         bitCntR  <= bitCntNext;
         posR     <= posNext;
         confirmR <= confirmNext;
         missR    <= missNext;
      end
   end

   // Registered outputs; a word is only presented when the receiver is locked
   always_ff @(posedge iClkOrb or posedge reset) begin
      if (reset) begin
         oParallel <= 12'd0;
         oPos      <= 5'd0;
         oVal      <= 1'b0;
         oLock     <= 1'b0;
         oSyncErr  <= 1'b0;
      end else begin
         oVal     <= wordOutS;
         oLock    <= (stateNext == LOCK);
         oSyncErr <= syncErrNext;
         if (wordOutS) begin
            oParallel <= histNextS[11:0];
            oPos      <= posR;
         end
      end
   end

endmodule

// File: tb/tb_orb_m16_rx.sv
// Self-checking bench for orb_m16_rx: phrase-level scenario table driving an
// M16 stream, with a word scoreboard filled as words are transmitted.
module tb_orb_m16_rx;

   logic        iClkOrb = 1'b0;
   logic        reset;
   logic        iOrbit;
   logic [11:0] oParallel;
   logic        oVal;
   logic [4:0]  oPos;
   logic        oLock;
   logic        oSyncErr;

   orb_m16_rx dut (
      .iClkOrb  (iClkOrb),
      .reset    (reset),
      .iOrbit   (iOrbit),
      .oParallel(oParallel),
      .oVal     (oVal),
      .oPos     (oPos),
      .oLock    (oLock),
      .oSyncErr (oSyncErr)
   );

   always #5 iClkOrb = ~iClkOrb;

   localparam int GOOD = 0, CORR = 1, TOG = 2, SLIP = 3, GARB = 4, RST = 5;
   localparam int O_NONE = 0, O_ALL = 1, O_31 = 2, O_NOT31 = 3, O_LT10 = 4;

   typedef struct {
      logic [11:0] word;
      logic [4:0]  pos;
      bit          gap;
   } exp_t;

   typedef struct {
      int mode;
      int outMode;
      bit expLock;
      int expErr;
   } row_t;

   exp_t   sbQ[$];
   exp_t   mon;
   row_t   rows[32];
   int     checks = 0;
   int     failures = 0;
   int     errCnt = 0;
   longint cyc = 0;
   longint lastVal = 0;
   bit     sbIgnore = 1'b0;
   bit     prevPushed = 1'b0;
   bit     obsLock;
   int     obsErr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic logic marker(input int p, input int mode);
      logic m;
      m = (p inside {2, 4, 6, 8, 18, 24, 26, 30});
      if (mode == CORR && p == 4) m = ~m;
      if (mode == TOG && p == 16) m = 1'b1;
      return m;
   endfunction

   function automatic bit wantOut(input int outMode, input int p);
      case (outMode)
         O_ALL:   return 1'b1;
         O_31:    return p == 31;
         O_NOT31: return p != 31;
         O_LT10:  return p < 10;
         default: return 1'b0;
      endcase
   endfunction

   always @(posedge iClkOrb) cyc <= cyc + 1;

   // Output monitor: sync error counting and scoreboard comparison
   always @(negedge iClkOrb) begin
      if (oSyncErr) errCnt++;
      if (oVal) begin
         if (sbQ.size() > 0) begin
            mon = sbQ.pop_front();
            chk("word_data", {52'd0, oParallel}, {52'd0, mon.word});
            chk("word_pos", {59'd0, oPos}, {59'd0, mon.pos});
            if (mon.gap) chk("oval_spacing", cyc - lastVal, 64'd48);
         end else if (!sbIgnore) begin
            checks++;
            failures++;
            $display("FAIL unexpected_oVal actual oPos=%0d oParallel=%0d required no strobe", oPos, oParallel);
         end
         lastVal = cyc;
      end
   end

   task automatic sendBit(input logic b, input int len);
      iOrbit = b;
      repeat (len) @(posedge iClkOrb);
      #1;
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      @(negedge iClkOrb);
      chk("midrst_oVal", {63'd0, oVal}, 64'd0);
      chk("midrst_oLock", {63'd0, oLock}, 64'd0);
      chk("midrst_oSyncErr", {63'd0, oSyncErr}, 64'd0);
      chk("midrst_oPos", {59'd0, oPos}, 64'd0);
      chk("midrst_oParallel", {52'd0, oParallel}, 64'd0);
      @(posedge iClkOrb);
      #1;
      reset = 1'b0;
      @(negedge iClkOrb);
      chk("postrst_oLock", {63'd0, oLock}, 64'd0);
      chk("postrst_oVal", {63'd0, oVal}, 64'd0);
      @(posedge iClkOrb);
      #1;
   endtask

   // Sends one phrase from global bit index startBit; a non-zero start is a
   // partial leading phrase that is never observed or expected on oVal.
   task automatic sendPhrase(input row_t r, input int startBit);
      logic [11:0] w;
      bit          want;
      sbIgnore = (r.mode == GARB);
      for (int p = 0; p < 32; p++) begin
         if (p == 1 && startBit == 0) begin
            obsLock = oLock;
            obsErr  = errCnt;
         end
         w    = {marker(p, r.mode), 11'($urandom)};
         want = wantOut(r.outMode, p) && (startBit == 0);
         if (r.mode == SLIP && p == 10) sbIgnore = 1'b1;
         if (want) sbQ.push_back('{w, 5'(p), prevPushed});
         prevPushed = want;
         for (int b = 11; b >= 0; b--) begin
            if (p * 12 + (11 - b) >= startBit) begin
               if (r.mode == RST && p == 10 && b == 9) pulseReset();
               sendBit(w[b], (r.mode == SLIP && p == 10 && b == 6) ? 8 : 4);
            end
         end
      end
   endtask

   initial begin
      row_t tailRow;
      rows[0]  = '{GOOD, O_NONE,  1'b0, 0};
      rows[1]  = '{GOOD, O_NONE,  1'b0, 0};
      rows[2]  = '{GOOD, O_31,    1'b0, 0};
      rows[3]  = '{GOOD, O_ALL,   1'b1, 0};
      rows[4]  = '{CORR, O_ALL,   1'b1, 0};
      rows[5]  = '{GOOD, O_ALL,   1'b1, 1};
      rows[6]  = '{TOG,  O_ALL,   1'b1, 1};
      rows[7]  = '{GOOD, O_ALL,   1'b1, 1};
      rows[8]  = '{CORR, O_ALL,   1'b1, 1};
      rows[9]  = '{CORR, O_ALL,   1'b1, 2};
      rows[10] = '{GOOD, O_ALL,   1'b1, 3};
      rows[11] = '{CORR, O_ALL,   1'b1, 3};
      rows[12] = '{CORR, O_ALL,   1'b1, 4};
      rows[13] = '{CORR, O_NOT31, 1'b1, 5};
      rows[14] = '{GOOD, O_NONE,  1'b0, 6};
      rows[15] = '{CORR, O_NONE,  1'b0, 6};
      rows[16] = '{GOOD, O_NONE,  1'b0, 6};
      rows[17] = '{GOOD, O_NONE,  1'b0, 6};
      rows[18] = '{GOOD, O_31,    1'b0, 6};
      rows[19] = '{GOOD, O_ALL,   1'b1, 6};
      rows[20] = '{TOG,  O_ALL,   1'b1, 6};
      rows[21] = '{SLIP, O_LT10,  1'b1, 6};
      rows[22] = '{GARB, O_NONE,  1'b1, 7};
      rows[23] = '{GARB, O_NONE,  1'b1, 8};
      rows[24] = '{GOOD, O_NONE,  1'b0, 9};
      rows[25] = '{GOOD, O_31,    1'b0, 9};
      rows[26] = '{GOOD, O_ALL,   1'b1, 9};
      rows[27] = '{RST,  O_LT10,  1'b1, 9};
      rows[28] = '{GOOD, O_NONE,  1'b0, 9};
      rows[29] = '{GOOD, O_NONE,  1'b0, 9};
      rows[30] = '{GOOD, O_31,    1'b0, 9};
      rows[31] = '{TOG,  O_ALL,   1'b1, 9};

      reset  = 1'b1;
      iOrbit = 1'b0;
      repeat (3) @(posedge iClkOrb);
      @(negedge iClkOrb);
      chk("rst_oVal", {63'd0, oVal}, 64'd0);
      chk("rst_oLock", {63'd0, oLock}, 64'd0);
      chk("rst_oSyncErr", {63'd0, oSyncErr}, 64'd0);
      chk("rst_oPos", {59'd0, oPos}, 64'd0);
      chk("rst_oParallel", {52'd0, oParallel}, 64'd0);
      @(posedge iClkOrb);
      #1;
      reset = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge iClkOrb);
      #1;

      // Leading partial phrase starting past the word-2 marker
      tailRow = '{GOOD, O_NONE, 1'b0, 0};
      sendPhrase(tailRow, $urandom_range(25, 383));

      for (int i = 0; i < 32; i++) begin
         sendPhrase(rows[i], 0);
         chk($sformatf("lock_row%0d", i), {63'd0, obsLock}, {63'd0, rows[i].expLock});
         chk($sformatf("syncerr_row%0d", i), 64'(obsErr), 64'(rows[i].expErr));
      end

      sendBit(iOrbit, 10);
      chk("scoreboard_drained", 64'(sbQ.size()), 64'd0);
      chk("final_lock", {63'd0, oLock}, 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
